// File: rtl/seg_bcd_encoder_if.sv
// ============================================================================
// Module      : seg_bcd_encoder_if
// Description : Load/busy/done handshake and segment result bundle between a
//               binary-value producer and the BCD 7-segment encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_bcd_encoder_if #(
    parameter int IN_BITS = 7
);
    logic [IN_BITS-1:0] value;
    logic               load;
    logic               busy;
    logic               done;
    logic               ovf;
    logic [13:0]        both7seg;

    modport master (
        output value, load,
        input  busy, done, ovf, both7seg
    );

    modport slave (
        input  value, load,
        output busy, done, ovf, both7seg
    );
endinterface

`default_nettype wire

// File: rtl/seg_bcd_encoder.sv
// ============================================================================
// Module      : seg_bcd_encoder
// Description : Sequential double-dabble binary-to-BCD converter feeding a
//               registered two-digit 7-segment word with overflow indication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_bcd_encoder #(
    parameter int IN_BITS    = 7,
    parameter bit BLANK_LEAD = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    seg_bcd_encoder_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_t;

    localparam logic [3:0]  C_LAST_CNT = 4'(IN_BITS - 1);
    localparam logic [13:0] C_OFF_WORD = ACTIVE_LOW ? 14'h3FFF : 14'h0000;
    localparam logic [6:0]  C_DASH     = 7'h40;

    state_t             r_state;
    logic [IN_BITS-1:0] r_shift;
    logic [7:0]         r_bcd;
    logic [3:0]         r_cnt;
    logic               r_ovf_n;

    logic [7:0]         w_bcd_adj;
    logic [6:0]         w_tens_seg;
    logic [6:0]         w_ones_seg;
    logic [13:0]        w_word;
    logic               w_value_ovf;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign w_value_ovf = (32'(bus.value) > 32'd99);

    always_comb begin
        w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? (r_bcd[3:0] + 4'd3) : r_bcd[3:0];
        w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? (r_bcd[7:4] + 4'd3) : r_bcd[7:4];

        // Overflow shows "--" and deliberately bypasses leading-zero blanking.
        if (r_ovf_n) begin
            w_tens_seg = C_DASH;
            w_ones_seg = C_DASH;
        end else begin
            w_tens_seg = (BLANK_LEAD && (r_bcd[7:4] == 4'd0)) ? 7'h00 : seg_of(r_bcd[7:4]);
            w_ones_seg = seg_of(r_bcd[3:0]);
        end

        w_word = ACTIVE_LOW ? ~{w_tens_seg, w_ones_seg} : {w_tens_seg, w_ones_seg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ovf_n      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.ovf      <= 1'b0;
            bus.both7seg <= C_OFF_WORD;
        end else begin
            bus.done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        r_shift  <= bus.value;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_ovf_n  <= w_value_ovf;
                        bus.busy <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Any hundreds carry falls off the top; only overflow values produce one.
                    r_bcd   <= {w_bcd_adj[6:0], r_shift[IN_BITS-1]};
                    r_shift <= {r_shift[IN_BITS-2:0], 1'b0};
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == C_LAST_CNT) begin
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    bus.both7seg <= w_word;
                    bus.ovf      <= r_ovf_n;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
